// File: rtl/int_to_fp_arbiter.sv
// int_to_fp_arbiter
// -----------------
// Shares one pipelined integer-to-float converter among NREQ requesters.
// Each cycle at most one pending request is granted, round-robin starting
// at rr_ptr. The granted operand is registered onto conv_int. A tag
// {valid, id} travels alongside the converter's pipeline so that each
// result can be returned to the requester that issued it.
//
// Parameters:
//   NREQ - number of requesters (2..8)
//   LAT  - converter latency, conv_int change to valid conv_fp (>= 1)
//   IDW  - requester id width, equal to clog2(NREQ)
//
// Ports:
//   clk        - clock, rising-edge
//   reset      - asynchronous active-high reset
//   req_valid  - per-requester request valid
//   req_int    - requester i operand in bits [32i+31:32i]
//   req_ready  - one-hot grant; a transfer happens on valid & ready
//   conv_int   - registered operand to the converter
//   conv_fp    - converter result
//   resp_valid - result valid this cycle
//   resp_id    - requester owning the result (held while idle)
//   resp_fp    - result, combinational pass-through of conv_fp
//   inflight   - conversions issued and not yet returned
module int_to_fp_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [32*NREQ-1:0]          req_int,
  output logic [NREQ-1:0]             req_ready,
  output logic [31:0]                 conv_int,
  input  logic [31:0]                 conv_fp,
  output logic                        resp_valid,
  output logic [IDW-1:0]              resp_id,
  output logic [31:0]                 resp_fp,
  output logic [$clog2(LAT+2)-1:0]    inflight
);

  localparam int CW = $clog2(LAT+2);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] next_ptr;
  logic           grant_any;
  logic           hs;

  // Tag stages 0..LAT-1; stage LAT is the resp_valid/resp_id register pair.
  logic           stage_v  [LAT];
  logic [IDW-1:0] stage_id [LAT];

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  // modulo NREQ (which need not be a power of two).
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // Grant is suppressed during reset so nothing is accepted that the
  // reset would immediately discard.
  always_comb begin
    req_ready = '0;
    if (!reset && grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign hs       = |req_ready;
  assign next_ptr = IDW'((int'(grant_id) + 1) % NREQ);
  assign resp_fp  = conv_fp;

  // Operand register, round-robin pointer, tag pipeline and in-flight
  // counter. The tag pipeline shifts every cycle regardless of traffic
  // because the converter itself never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      conv_int   <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      inflight   <= '0;
      for (int k = 0; k < LAT; k++) begin
        stage_v[k]  <= 1'b0;
        stage_id[k] <= '0;
      end
    end else begin
      stage_v[0] <= hs;
      if (hs) begin
        stage_id[0] <= grant_id;
        conv_int    <= req_int[32*int'(grant_id) +: 32];
        rr_ptr      <= next_ptr;
      end
      for (int k = 1; k < LAT; k++) begin
        stage_v[k]  <= stage_v[k-1];
        stage_id[k] <= stage_id[k-1];
      end
      resp_valid <= stage_v[LAT-1];
      if (stage_v[LAT-1]) begin
        resp_id <= stage_id[LAT-1];
      end
      // A new issue and a completing result in the same cycle cancel out.
      case ({hs, resp_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
